fx2_stream_arbiter: RTL and testbench

// - Shares the FX2 Slave FIFO write bus (16-bit, IFCLK-synchronous) between two stream-in sources.
// - Source 0 targets EP6 and source 1 targets EP8.
// - Grants at packet granularity, round-robin, and inserts an address-setup gap on every grant.
// - Honours each endpoint's full flag and optionally commits short packets via PKTEND.
// - Sits between the data generators/capture logic and the FX2 pins, replacing a fixed single-endpoint writer.

---
 rtl/fx2_stream_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_fx2_stream_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_stream_arbiter.sv
// ---------------------------------------------------------------------------
// fx2_stream_arbiter
//
// Shares the FX2 Slave FIFO write bus (16-bit, IFCLK synchronous) between two
// stream-in sources. Source 0 writes to EP6, source 1 writes to EP8.
// Arbitration is per packet and round-robin. Every grant begins with an
// address-setup gap, so FIFOADR is stable before the first SLWR of the burst.
// Each endpoint's not-full flag is honoured.
//
// Optional feature (compile-time macro FX2_ARB_PKTEND_EN):
//   When defined, a word with s*_last set commits a short packet. The
//   arbiter first leaves one cycle with SLWR high, then pulses PKTEND low
//   for one cycle. When undefined, s*_last is ignored and fx2_pkt_end is
//   held at 1.
//
// Ports
//   fx2_ifclk     in   interface clock, all logic on the rising edge
//   reset_n       in   asynchronous active-low reset
//   s0_data/valid/last, s0_ready     source 0 stream (EP6)
//   s1_data/valid/last, s1_ready     source 1 stream (EP8)
//   fx2_flagc     in   EP6 not-full (1 = space available)
//   fx2_flagd     in   EP8 not-full (1 = space available)
//   fx2_fdata     out  FIFO data bus, 0 whenever no write is in progress
//   fx2_faddr     out  FIFO address, registered at grant time
//   fx2_slwr      out  write strobe, active low
//   fx2_slrd      out  read strobe, held at 1
//   fx2_sloe      out  output enable, held at 1
//   fx2_pkt_end   out  packet-end strobe, active low
//   grant         out  one-hot active source, 2'b00 when no source is granted
// ---------------------------------------------------------------------------
module fx2_stream_arbiter #(
    parameter int         PKT_WORDS  = 256,
    parameter logic [1:0] EP_ADDR0   = 2'b10,
    parameter logic [1:0] EP_ADDR1   = 2'b11,
    parameter int         ADDR_SETUP = 2
) (
    input  logic        fx2_ifclk,
    input  logic        reset_n,
    input  logic [15:0] s0_data,
    input  logic        s0_valid,
    input  logic        s0_last,
    output logic        s0_ready,
    input  logic [15:0] s1_data,
    input  logic        s1_valid,
    input  logic        s1_last,
    output logic        s1_ready,
    input  logic        fx2_flagc,
    input  logic        fx2_flagd,
    output logic [15:0] fx2_fdata,
    output logic [1:0]  fx2_faddr,
    output logic        fx2_slwr,
    output logic        fx2_slrd,
    output logic        fx2_sloe,
    output logic        fx2_pkt_end,
    output logic [1:0]  grant
);

    localparam int CNT_W = $clog2(PKT_WORDS + 1);
    localparam int SET_W = $clog2(ADDR_SETUP + 1);

    localparam logic [CNT_W-1:0] PKT_LAST   = CNT_W'(PKT_WORDS - 1);
    localparam logic [SET_W-1:0] SETUP_LAST = SET_W'(ADDR_SETUP - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
`ifdef FX2_ARB_PKTEND_EN
    localparam logic [1:0] ST_PKTEND = 2'd3;
`endif

    logic [1:0]       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       faddr_q, faddr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SET_W-1:0] setup_q, setup_d;
    // Priority pointer: the source that wins when both are valid in IDLE.
    logic             ptr_q, ptr_d;
`ifdef FX2_ARB_PKTEND_EN
    // Low in the SLWR-high gap cycle, high in the PKTEND-low cycle.
    logic             pend_q, pend_d;
`endif

    logic        sel_s1;
    logic        sel_valid;
    logic        sel_flag;
    logic [15:0] sel_data;
    logic        write_en;
    logic        pick_s1;
`ifdef FX2_ARB_PKTEND_EN
    logic        sel_last;
`else
    logic        unused_last;
    assign unused_last = s0_last ^ s1_last;
`endif

    // Multiplex the granted source. A word moves only in WRITE, and only
    // when the source has data and the endpoint has room. A stall leaves
    // the grant untouched.
    always_comb begin
        sel_s1    = grant_q[1];
        sel_valid = sel_s1 ? s1_valid  : s0_valid;
        sel_flag  = sel_s1 ? fx2_flagd : fx2_flagc;
        sel_data  = sel_s1 ? s1_data   : s0_data;
`ifdef FX2_ARB_PKTEND_EN
        sel_last  = sel_s1 ? s1_last   : s0_last;
`endif
        write_en  = (state_q == ST_WRITE) && sel_valid && sel_flag;
        pick_s1   = (s0_valid && s1_valid) ? ptr_q : s1_valid;
    end

    // Next-state logic. Every grant passes through IDLE and SETUP before
    // writing. The end of a packet clears the word count, toggles the
    // pointer and drops the grant.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        faddr_d = faddr_q;
        count_d = count_q;
        setup_d = setup_q;
        ptr_d   = ptr_q;
`ifdef FX2_ARB_PKTEND_EN
        pend_d  = pend_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s0_valid || s1_valid) begin
                    grant_d = pick_s1 ? 2'b10 : 2'b01;
                    faddr_d = pick_s1 ? EP_ADDR1 : EP_ADDR0;
                    setup_d = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_q == SETUP_LAST) begin
                    state_d = ST_WRITE;
                end else begin
                    setup_d = setup_q + SET_W'(1);
                end
            end
            ST_WRITE: begin
                if (write_en) begin
                    if (count_q == PKT_LAST) begin
                        count_d = '0;
                        ptr_d   = ~ptr_q;
                        grant_d = 2'b00;
                        state_d = ST_IDLE;
`ifdef FX2_ARB_PKTEND_EN
                    end else if (sel_last) begin
                        // Short packet. A last flag on the final full-size
                        // word is handled above, because the FX2 commits
                        // that packet on its own.
                        count_d = count_q + CNT_W'(1);
                        pend_d  = 1'b0;
                        state_d = ST_PKTEND;
`endif
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
`ifdef FX2_ARB_PKTEND_EN
            ST_PKTEND: begin
                if (!pend_q) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d  = 1'b0;
                    count_d = '0;
                    ptr_d   = ~ptr_q;
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State registers. Reset returns everything to idle at once. A
    // partially written packet stays uncommitted inside the FX2.
    always_ff @(posedge fx2_ifclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            faddr_q <= EP_ADDR0;
            count_q <= '0;
            setup_q <= '0;
            ptr_q   <= 1'b0;
`ifdef FX2_ARB_PKTEND_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            faddr_q <= faddr_d;
            count_q <= count_d;
            setup_q <= setup_d;
            ptr_q   <= ptr_d;
`ifdef FX2_ARB_PKTEND_EN
            pend_q  <= pend_d;
`endif
        end
    end

    // Bus outputs. The data bus is forced to zero whenever SLWR is high.
    always_comb begin
        fx2_slwr  = ~write_en;
        fx2_fdata = write_en ? sel_data : 16'h0000;
        s0_ready  = write_en & grant_q[0];
        s1_ready  = write_en & grant_q[1];
        fx2_faddr = faddr_q;
        grant     = grant_q;
        fx2_slrd  = 1'b1;
        fx2_sloe  = 1'b1;
`ifdef FX2_ARB_PKTEND_EN
        fx2_pkt_end = ~((state_q == ST_PKTEND) && pend_q);
`else
        fx2_pkt_end = 1'b1;
`endif
    end

endmodule

// File: tb/tb_fx2_stream_arbiter.sv
`timescale 1ns/1ps
module tb_fx2_stream_arbiter;

    localparam logic [1:0] EP_ADDR0 = 2'b10;
    localparam logic [1:0] EP_ADDR1 = 2'b11;

    typedef struct packed {
        logic [1:0]  faddr;
        logic [1:0]  grant;
        logic [15:0] data;
    } wr_t;

    logic        fx2_ifclk;
    logic        reset_n;
    logic [15:0] s0_data, s1_data;
    logic        s0_valid, s1_valid, s0_last, s1_last, s0_ready, s1_ready;
    logic        fx2_flagc, fx2_flagd;
    logic [15:0] fx2_fdata;
    logic [1:0]  fx2_faddr, grant;
    logic        fx2_slwr, fx2_slrd, fx2_sloe, fx2_pkt_end;

    int tests_run    = 0;
    int tests_failed = 0;

    wr_t exp_q[$];

    // Source model state: fired-word index, words still to offer, next
    // word index to push into the scoreboard, and the index that carries last.
    int s0_idx = 0, s1_idx = 0;
    int s0_avail = 0, s1_avail = 0;
    int s0_push = 0, s1_push = 0;
    int s0_last_at = -1, s1_last_at = -1;

    int burst_writes = 0;
    int run_len = 0;
    int exp_len = 256;
    logic [1:0] prev_grant = 2'b00;

    fx2_stream_arbiter dut (
        .fx2_ifclk   (fx2_ifclk),
        .reset_n     (reset_n),
        .s0_data     (s0_data),
        .s0_valid    (s0_valid),
        .s0_last     (s0_last),
        .s0_ready    (s0_ready),
        .s1_data     (s1_data),
        .s1_valid    (s1_valid),
        .s1_last     (s1_last),
        .s1_ready    (s1_ready),
        .fx2_flagc   (fx2_flagc),
        .fx2_flagd   (fx2_flagd),
        .fx2_fdata   (fx2_fdata),
        .fx2_faddr   (fx2_faddr),
        .fx2_slwr    (fx2_slwr),
        .fx2_slrd    (fx2_slrd),
        .fx2_sloe    (fx2_sloe),
        .fx2_pkt_end (fx2_pkt_end),
        .grant       (grant)
    );

    initial begin
        fx2_ifclk = 1'b0;
        forever #5 fx2_ifclk = ~fx2_ifclk;
    end

    function automatic logic [15:0] word0(int i);
        return 16'(40960 + i);
    endfunction

    function automatic logic [15:0] word1(int i);
        return 16'(45056 + i);
    endfunction

    function automatic void refreshSources();
        s0_data  = word0(s0_idx);
        s1_data  = word1(s1_idx);
        s0_valid = (s0_avail > 0);
        s1_valid = (s1_avail > 0);
        s0_last  = (s0_idx == s0_last_at);
        s1_last  = (s1_idx == s1_last_at);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Offer n more words from a source and queue the writes they must produce.
    task automatic applyStimulus(input int src, input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            if (src == 0) begin
                e.faddr = EP_ADDR0; e.grant = 2'b01; e.data = word0(s0_push);
                s0_push++;
            end else begin
                e.faddr = EP_ADDR1; e.grant = 2'b10; e.data = word1(s1_push);
                s1_push++;
            end
            exp_q.push_back(e);
        end
        if (src == 0) s0_avail += n; else s1_avail += n;
        refreshSources();
    endtask

    task automatic waitWrites(input string name, input int n);
        int c;
        c = 0;
        while (burst_writes < n && c < 3000) begin
            @(posedge fx2_ifclk);
            c++;
        end
        if (burst_writes < n) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s_timeout: writes=%0d required=%0d", name, burst_writes, n);
        end
    endtask

    task automatic waitDrain(input string name, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge fx2_ifclk);
            c++;
        end
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s_drain: pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge fx2_ifclk);
        checkOutput({name, "_idle_grant"}, 32'(grant), 32'(2'b00));
        checkOutput({name, "_idle_slwr"}, 32'(fx2_slwr), 32'd1);
    endtask

    // Source driver: a word leaves the source when ready is high at the edge.
    initial begin
        logic f0, f1;
        refreshSources();
        forever begin
            @(negedge fx2_ifclk);
            f0 = s0_ready;
            f1 = s1_ready;
            @(posedge fx2_ifclk);
            #1;
            if (f0) begin s0_idx++; s0_avail--; end
            if (f1) begin s1_idx++; s1_avail--; end
            refreshSources();
        end
    end

    // Monitor: every bus write is popped from the scoreboard and compared.
    // Each grant's run length is checked when the grant falls.
    initial begin
        wr_t e;
        forever begin
            @(negedge fx2_ifclk);
            if (reset_n) begin
                if (!fx2_slwr) begin
                    burst_writes++;
                    run_len++;
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL unexpected_write: actual=%0h expected=none", fx2_fdata);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("sb_write", {12'h0, fx2_faddr, grant, fx2_fdata}, {12'h0, e});
                    end
                    checkOutput("pktend_vs_slwr", 32'(fx2_pkt_end), 32'd1);
                end else begin
                    checkOutput("fdata_idle", 32'(fx2_fdata), 32'd0);
                end
                if (grant == 2'b00 && prev_grant != 2'b00) begin
                    checkOutput("burst_len", run_len, exp_len);
                    run_len = 0;
                end
                prev_grant = grant;
            end else begin
                run_len    = 0;
                prev_grant = 2'b00;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lows;
        reset_n   = 1'b0;
        fx2_flagc = 1'b1;
        fx2_flagd = 1'b1;

        // Reset values.
        repeat (3) @(negedge fx2_ifclk);
        checkOutput("rst_slwr",    32'(fx2_slwr),    32'd1);
        checkOutput("rst_grant",   32'(grant),       32'd0);
        checkOutput("rst_faddr",   32'(fx2_faddr),   32'(EP_ADDR0));
        checkOutput("rst_pkt_end", 32'(fx2_pkt_end), 32'd1);
        checkOutput("rst_fdata",   32'(fx2_fdata),   32'd0);
        checkOutput("rst_ready",   {30'd0, s1_ready, s0_ready}, 32'd0);
        checkOutput("rst_slrd_sloe", {30'd0, fx2_slrd, fx2_sloe}, 32'd3);
        reset_n = 1'b1;

        // Only s0 valid: FIFOADR set in cycle 1, first SLWR low in cycle 3.
        @(posedge fx2_ifclk); #1;
        burst_writes = 0;
        applyStimulus(0, 256);
        @(negedge fx2_ifclk);
        checkOutput("t1_c0_slwr",  32'(fx2_slwr),  32'd1);
        @(negedge fx2_ifclk);
        checkOutput("t1_c1_faddr", 32'(fx2_faddr), 32'(EP_ADDR0));
        checkOutput("t1_c1_grant", 32'(grant),     32'(2'b01));
        checkOutput("t1_c1_slwr",  32'(fx2_slwr),  32'd1);
        @(negedge fx2_ifclk);
        checkOutput("t1_c2_slwr",  32'(fx2_slwr),  32'd1);
        @(negedge fx2_ifclk);
        checkOutput("t1_c3_slwr",  32'(fx2_slwr),  32'd0);
        waitDrain("t1", 1000);

        // s1 burst with EP8 full for 10 cycles after word 100.
        @(posedge fx2_ifclk); #1;
        burst_writes = 0;
        applyStimulus(1, 256);
        waitWrites("t3", 100);
        #1;
        fx2_flagd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge fx2_ifclk);
            checkOutput("t3_stall_slwr",  32'(fx2_slwr), 32'd1);
            checkOutput("t3_stall_grant", 32'(grant),    32'(2'b10));
        end
        @(posedge fx2_ifclk); #1;
        fx2_flagd = 1'b1;
        waitDrain("t3", 1000);
        checkOutput("t3_total_writes", burst_writes, 256);

        // Both sources valid: s0, s1, s0, each a full packet.
        @(posedge fx2_ifclk); #1;
        applyStimulus(0, 256);
        applyStimulus(1, 256);
        applyStimulus(0, 256);
        waitDrain("t2", 2500);

        // Reset pulse mid s1 burst at word 50, then s0 wins the first grant.
        @(posedge fx2_ifclk); #1;
        burst_writes = 0;
        applyStimulus(1, 256);
        waitWrites("t4", 50);
        #1;
        reset_n = 1'b0;
        @(negedge fx2_ifclk);
        checkOutput("t4_rst_slwr",  32'(fx2_slwr),  32'd1);
        checkOutput("t4_rst_grant", 32'(grant),     32'd0);
        checkOutput("t4_rst_faddr", 32'(fx2_faddr), 32'(EP_ADDR0));
        exp_q.delete();
        s0_avail = 0;
        s1_avail = 0;
        s0_push  = s0_idx;
        s1_push  = s1_idx;
        refreshSources();
        @(negedge fx2_ifclk);
        reset_n = 1'b1;
        @(posedge fx2_ifclk); #1;
        applyStimulus(0, 256);
        applyStimulus(1, 256);
        repeat (2) @(negedge fx2_ifclk);
        checkOutput("t4_first_grant", 32'(grant), 32'(2'b01));
        waitDrain("t4", 2000);

        // s0_last on the 20th word of an s0 packet.
        @(posedge fx2_ifclk); #1;
        burst_writes = 0;
        s0_last_at = s0_idx + 19;
`ifdef FX2_ARB_PKTEND_EN
        exp_len = 20;
        applyStimulus(0, 20);
        waitWrites("t5", 20);
        @(negedge fx2_ifclk);
        checkOutput("t5_gap_slwr",    32'(fx2_slwr),    32'd1);
        checkOutput("t5_gap_pkt_end", 32'(fx2_pkt_end), 32'd1);
        checkOutput("t5_gap_grant",   32'(grant),       32'(2'b01));
        @(negedge fx2_ifclk);
        checkOutput("t5_pkt_end_low", 32'(fx2_pkt_end), 32'd0);
        checkOutput("t5_pe_slwr",     32'(fx2_slwr),    32'd1);
        @(negedge fx2_ifclk);
        checkOutput("t5_after_pkt_end", 32'(fx2_pkt_end), 32'd1);
        checkOutput("t5_after_grant",   32'(grant),       32'd0);
        waitDrain("t5", 200);
        checkOutput("t5_total_writes", burst_writes, 20);
        exp_len = 256;
`else
        applyStimulus(0, 256);
        lows = 0;
        for (int c = 0; c < 1000 && exp_q.size() != 0; c++) begin
            @(negedge fx2_ifclk);
            if (!fx2_pkt_end) lows++;
        end
        checkOutput("t5_pkt_end_lows", lows, 0);
        waitDrain("t5", 1000);
        checkOutput("t5_total_writes", burst_writes, 256);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
